// File: rtl/qpsk_symbol_packer.sv
// QPSK demod output stage: samples I/Q on the symbol strobe, emits raw I/Q words or
// packed 2-bit hard decisions as fixed-length AXI-stream packets through a small FIFO.
module qpsk_symbol_packer #(
  parameter int WIDTH   = 16,
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst_n,
  input  logic                 clear,
  input  logic [2*WIDTH-1:0]   i_tdata,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  input  logic                 sym_stb,
  input  logic                 mode,
  input  logic [CNT_W-1:0]     pkt_len,
  output logic [2*WIDTH-1:0]   o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [CNT_W-1:0]     overflow_cnt,
  output logic                 overflow,
  output logic [FIFO_AW:0]     fifo_level
);

  localparam int DW    = 2 * WIDTH;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int SW    = $clog2(WIDTH + 1);

  // Packet / word assembly state
  logic [CNT_W-1:0] word_cnt;
  logic [SW-1:0]    sym_cnt;
  logic [DW-1:0]    partial;
  logic             active_mode;
  logic [CNT_W-1:0] cur_len;

  // FIFO state
  logic [DW:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  // Combinational decode
  logic             capture;
  logic             at_start;
  logic             eff_mode;
  logic [CNT_W-1:0] eff_len;
  logic [1:0]       dec;
  logic [DW-1:0]    packed_word;
  logic [DW-1:0]    push_word;
  logic             push_last;
  logic             word_done;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign i_tready = 1'b1;

  always_comb begin
    capture     = sym_stb & i_tvalid;
    at_start    = (word_cnt == '0) && (sym_cnt == '0);
    // Mode and length are latched only at a packet boundary; mid-packet changes wait.
    eff_mode    = at_start ? mode : active_mode;
    if (at_start)
      eff_len = (pkt_len == '0) ? CNT_W'(1) : pkt_len;
    else
      eff_len = cur_len;
    dec         = {i_tdata[DW-1], i_tdata[WIDTH-1]};
    packed_word = (partial << 2) | DW'(dec);
    push_word   = eff_mode ? packed_word : i_tdata;
    push_last   = (word_cnt == (eff_len - CNT_W'(1)));
    word_done   = capture && !clear && (!eff_mode || (sym_cnt == SW'(WIDTH - 1)));
    full        = (count == (FIFO_AW+1)'(DEPTH));
    pop         = o_tvalid && o_tready;
    push_ok     = word_done && (!full || pop);
    drop        = word_done && !push_ok;
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      word_cnt     <= '0;
      sym_cnt      <= '0;
      partial      <= '0;
      active_mode  <= 1'b0;
      cur_len      <= CNT_W'(1);
      overflow     <= 1'b0;
      overflow_cnt <= '0;
    end else if (clear) begin
      word_cnt     <= '0;
      sym_cnt      <= '0;
      partial      <= '0;
      active_mode  <= 1'b0;
      cur_len      <= CNT_W'(1);
      overflow     <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      if (at_start) begin
        active_mode <= mode;
        cur_len     <= eff_len;
      end
      if (capture && eff_mode) begin
        if (word_done) begin
          sym_cnt <= '0;
          partial <= '0;
        end else begin
          sym_cnt <= sym_cnt + SW'(1);
          partial <= packed_word;
        end
      end
      // A dropped word leaves the word counter alone so later tlast positions stay aligned.
      if (push_ok)
        word_cnt <= push_last ? '0 : word_cnt + CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (overflow_cnt != '1)
          overflow_cnt <= overflow_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ce_clk) begin
    if (push_ok)
      mem[wr_ptr] <= {push_last, push_word};
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Handshake: a word transfers on a cycle where o_tvalid && o_tready at the rising edge;
  // while o_tvalid && !o_tready the head entry, and hence o_tdata/o_tlast, is held.
  assign o_tvalid   = (count != '0);
  assign o_tdata    = o_tvalid ? mem[rd_ptr][DW-1:0] : '0;
  assign o_tlast    = o_tvalid ? mem[rd_ptr][DW] : 1'b0;
  assign fifo_level = count;

endmodule

// File: tb/tb_qpsk_symbol_packer.sv
// Directed and randomized bench for qpsk_symbol_packer against a queue-based reference model.
module tb_qpsk_symbol_packer;

  localparam int W     = 16;
  localparam int AW    = 4;
  localparam int CW    = 16;
  localparam int DEPTH = 16;

  logic          ce_clk = 1'b0;
  logic          ce_rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [2*W-1:0] i_tdata = '0;
  logic          i_tvalid = 1'b0;
  logic          i_tready;
  logic          sym_stb = 1'b0;
  logic          mode = 1'b0;
  logic [CW-1:0] pkt_len = '0;
  logic [2*W-1:0] o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          o_tready = 1'b0;
  logic [CW-1:0] overflow_cnt;
  logic          overflow;
  logic [AW:0]   fifo_level;

  qpsk_symbol_packer #(.WIDTH(W), .FIFO_AW(AW), .CNT_W(CW)) dut (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n), .clear(clear),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .sym_stb(sym_stb), .mode(mode), .pkt_len(pkt_len),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .overflow_cnt(overflow_cnt), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 ce_clk = ~ce_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: expected output FIFO holds {tlast, word}
  logic [2*W:0] exp_q[$];
  logic [1:0]   sym_q[$];
  logic         m_mode;
  int           m_len;
  int           m_wcnt;
  int           m_ovf_cnt;
  logic         m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    sym_q.delete();
    m_mode    = 1'b0;
    m_len     = 1;
    m_wcnt    = 0;
    m_ovf_cnt = 0;
    m_ovf     = 1'b0;
  endtask

  task automatic model_edge();
    logic       done;
    logic       last;
    logic [2*W-1:0] w;
    if (!ce_rst_n || clear) begin
      model_reset();
      return;
    end
    if (exp_q.size() > 0 && o_tready)
      void'(exp_q.pop_front());
    if (sym_stb && i_tvalid) begin
      if (m_wcnt == 0 && sym_q.size() == 0) begin
        m_mode = mode;
        m_len  = (pkt_len == 0) ? 1 : int'(pkt_len);
      end
      done = 1'b0;
      w    = '0;
      if (!m_mode) begin
        done = 1'b1;
        w    = i_tdata;
      end else begin
        sym_q.push_back({i_tdata[2*W-1], i_tdata[W-1]});
        if (sym_q.size() == W) begin
          for (int i = 0; i < W; i++)
            w = w | ((2*W)'(sym_q[i]) << (2 * (W - 1 - i)));
          sym_q.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (exp_q.size() < DEPTH) begin
          last = (m_wcnt == m_len - 1);
          exp_q.push_back({last, w});
          m_wcnt = last ? 0 : m_wcnt + 1;
        end else begin
          m_ovf = 1'b1;
          if (m_ovf_cnt < 65535) m_ovf_cnt++;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("i_tready", 64'(i_tready), 64'(1));
    chk("o_tvalid", 64'(o_tvalid), 64'(exp_q.size() != 0));
    chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
    if (exp_q.size() != 0) begin
      chk("o_tdata", 64'(o_tdata), 64'(exp_q[0][2*W-1:0]));
      chk("o_tlast", 64'(o_tlast), 64'(exp_q[0][2*W]));
    end
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf_cnt));
  endtask

  task automatic tick();
    @(posedge ce_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic strobe(input logic [2*W-1:0] d);
    sym_stb  = 1'b1;
    i_tvalid = 1'b1;
    i_tdata  = d;
    tick();
    sym_stb  = 1'b0;
  endtask

  task automatic idle(input int n);
    sym_stb = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  int nw;
  int lasts[$];

  initial begin
    model_reset();
    // Reset state
    repeat (3) begin
      tick();
      chk("rst_o_tdata", 64'(o_tdata), 64'(0));
      chk("rst_o_tlast", 64'(o_tlast), 64'(0));
    end
    ce_rst_n = 1'b1;

    // Raw mode, pkt_len 4, strobe every third valid sample
    mode = 1'b0; pkt_len = 16'd4; o_tready = 1'b1; i_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (2) begin
        i_tdata = $urandom;
        tick();
      end
      strobe({16'(2*k + 1), 16'(2*k + 2)});
    end
    chk("t1_last_data", 64'(o_tdata), 64'h0007_0008);
    chk("t1_last_flag", 64'(o_tlast), 64'(1));
    idle(3);

    // Packed mode, alternating (+,+) and (-,-), one-word packets
    mode = 1'b1; pkt_len = 16'd1;
    for (int k = 0; k < W; k++)
      strobe((k % 2 == 0) ? 32'h0001_0001 : 32'h8000_8000);
    chk("t2_word", 64'(o_tdata), 64'h3333_3333);
    chk("t2_last", 64'(o_tlast), 64'(1));
    strobe(32'h8000_0001);
    idle(4);
    chk("t2_partial_level", 64'(fifo_level), 64'(0));
    pulse_clear();

    // Overflow with stalled output, then drain with pkt_len 8
    mode = 1'b0; pkt_len = 16'd8; o_tready = 1'b0;
    for (int k = 0; k < 20; k++) strobe($urandom);
    chk("t3_level", 64'(fifo_level), 64'(16));
    chk("t3_ovf_cnt", 64'(overflow_cnt), 64'(4));
    chk("t3_ovf", 64'(overflow), 64'(1));
    o_tready = 1'b1;
    nw = 0;
    lasts.delete();
    repeat (20) begin
      if (o_tvalid && o_tready) begin
        nw++;
        if (o_tlast) lasts.push_back(nw);
      end
      tick();
    end
    chk("t3_words", 64'(nw), 64'(16));
    chk("t3_nlast", 64'(lasts.size()), 64'(2));
    if (lasts.size() == 2) begin
      chk("t3_last0", 64'(lasts[0]), 64'(8));
      chk("t3_last1", 64'(lasts[1]), 64'(16));
    end

    // Mode change mid-packet applies at next packet start
    pulse_clear();
    mode = 1'b0; pkt_len = 16'd4;
    strobe(32'h1111_2222);
    strobe(32'h3333_4444);
    mode = 1'b1;
    strobe(32'h5555_6666);
    strobe(32'h7777_8888);
    chk("t4_raw_last", 64'(o_tdata), 64'h7777_8888);
    for (int k = 0; k < W; k++) strobe($urandom);
    idle(2);
    pulse_clear();

    // Strobe without valid, then clear with queued words and a same-edge strobe
    mode = 1'b0; sym_stb = 1'b1; i_tvalid = 1'b0;
    repeat (10) tick();
    chk("t5_no_capture", 64'(fifo_level), 64'(0));
    o_tready = 1'b0;
    for (int k = 0; k < 5; k++) strobe($urandom);
    chk("t5_queued", 64'(fifo_level), 64'(5));
    clear = 1'b1; sym_stb = 1'b1; i_tvalid = 1'b1; i_tdata = $urandom;
    tick();
    clear = 1'b0; sym_stb = 1'b0;
    chk("t5_clr_valid", 64'(o_tvalid), 64'(0));
    chk("t5_clr_level", 64'(fifo_level), 64'(0));
    chk("t5_clr_cnt", 64'(overflow_cnt), 64'(0));

    // Asynchronous reset mid-packet with words queued and overflow set
    pkt_len = 16'd3;
    for (int k = 0; k < 18; k++) strobe($urandom);
    chk("t6_pre_valid", 64'(o_tvalid), 64'(1));
    chk("t6_pre_ovf", 64'(overflow), 64'(1));
    #3;
    ce_rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_valid", 64'(o_tvalid), 64'(0));
    chk("t6_async_level", 64'(fifo_level), 64'(0));
    chk("t6_async_ovf", 64'(overflow), 64'(0));
    tick();
    tick();
    ce_rst_n = 1'b1;
    o_tready = 1'b1;
    strobe(32'hA000_0001);
    chk("t6_w1_last", 64'(o_tlast), 64'(0));
    strobe(32'hA000_0002);
    chk("t6_w2_last", 64'(o_tlast), 64'(0));
    strobe(32'hA000_0003);
    chk("t6_w3_last", 64'(o_tlast), 64'(1));
    idle(2);

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      sym_stb  = ($urandom_range(0, 1) == 1);
      i_tvalid = ($urandom_range(0, 3) != 0);
      i_tdata  = $urandom;
      o_tready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0) pkt_len = 16'($urandom_range(0, 5));
      clear = ($urandom_range(0, 299) == 0);
      tick();
    end
    clear = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qpsk_symbol_packer.md
Name: qpsk_symbol_packer

Overview:
- Parametrised successor of the QPSK demod output stage. Samples the synchronised I/Q stream on a symbol strobe and emits one symbol-rate AXI-stream toward axi_wrapper s_axis_data.
- Two runtime modes: raw I/Q words, or packed hard decisions at 2 bits/symbol.
- Fixed-length packets with tlast. Output is buffered in a FIFO; overflow is counted instead of corrupting framing.

Parameters:
- WIDTH, 16, bits per I or Q component. Output word is 2*WIDTH bits.
- FIFO_AW, 4, log2 of output FIFO depth (default 16 entries).
- CNT_W, 16, width of the packet-length input and the overflow counter.

Ports:
- ce_clk  in  1  block clock.
- ce_rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush (driven by clear_tx_seqnum).
- i_tdata  in  2*WIDTH  {I, Q}, two's complement.
- i_tvalid  in  1  sample valid.
- i_tready  out  1  constant 1. The input is a continuous sample stream and is never stalled.
- sym_stb  in  1  symbol strobe from the bit-sync.
- mode  in  1  0 = raw I/Q, 1 = packed hard decisions.
- pkt_len  in  CNT_W  output words per packet.
- o_tdata  out  2*WIDTH  output word.
- o_tlast  out  1  last word of a packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  downstream ready.
- overflow_cnt  out  CNT_W  dropped-word count, saturating.
- overflow  out  1  sticky; set on the first drop, cleared only by reset or clear.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (ce_rst_n low, asynchronous): all of the following are 0:
  - o_tvalid, o_tlast, o_tdata
  - overflow_cnt, overflow, fifo_level
  - word counter, symbol-in-word counter, partial-word register, active_mode
- i_tready = 1 at all times, including during reset.
- Capture: a symbol is captured on a rising ce_clk edge only when sym_stb && i_tvalid. If sym_stb is high and i_tvalid is low, the strobe is ignored.
- active_mode:
  - Loaded from mode only when word counter == 0 and symbol-in-word counter == 0.
  - A mode change in mid-packet takes effect at the next packet start.
- Raw mode: each captured symbol produces one word, equal to i_tdata unmodified.
- Packed mode:
  - Per symbol: d = {I[WIDTH-1], Q[WIDTH-1]}; a negative component gives 1.
  - WIDTH symbols fill one word, MSB-first: the first symbol goes in bits [2W-1:2W-2], the last in bits [1:0].
  - The word is complete on the WIDTH-th capture.
- Framing:
  - Effective length L = max(pkt_len, 1). pkt_len is sampled at each packet start.
  - The word counter increments on each successful FIFO push.
  - o_tlast is stored with the word for which the counter == L-1; the counter then wraps to 0.
- FIFO write: a completed word is written on the same edge as its completing capture.
  - Latency: o_tvalid rises the cycle after the completing edge when the FIFO was empty. There is no combinational path from input to output.
- Overflow (FIFO full at the push edge):
  - The word is dropped; overflow_cnt += 1 (saturating at all-ones); overflow is set.
  - The word counter does NOT advance, so later packets keep correct tlast positions.
  - The symbol-in-word counter still resets to 0, so no partial word is carried over.
- Simultaneous push and pop when full: the pop frees a slot and the push succeeds, with no drop.
- Output handshake (standard AXI):
  - o_tdata and o_tlast hold stable while o_tvalid && !o_tready.
  - An entry pops on o_tvalid && o_tready.
  - fifo_level = pushes - pops, and updates on the same edge.
- clear (synchronous, priority over capture on the same edge):
  - Empties the FIFO.
  - Zeroes all counters, the partial word, overflow and overflow_cnt.
  - o_tvalid is 0 the next cycle.
- Reset or clear in mid-packet discards the partial packet. The next word starts a fresh packet.

Test Plan:
- Reset release, raw mode, pkt_len=4, o_tready=1, strobe on every 3rd valid sample with I/Q = 0x0001_0002, 0x0003_0004, … -> 4 words out in order, o_tlast only on the 4th word (0x0007_0008), each o_tvalid one cycle after its strobe.
- Packed mode, WIDTH=16, 16 symbols alternating (+,+) and (-,-), pkt_len=1 -> one word 0x3333_3333 with o_tlast=1. A 17th symbol alone produces no output.
- Raw mode, o_tready=0, 20 strobes, FIFO_AW=4 -> fifo_level=16, overflow_cnt=4, overflow=1. Release o_tready with pkt_len=8 -> 16 words out, tlast on words 8 and 16.
- Toggle mode from 0 to 1 after 2 of 4 words (pkt_len=4) -> remaining 2 words are raw; the next packet is packed.
- sym_stb high with i_tvalid low for 10 cycles -> no capture, fifo_level=0. Assert clear with 5 words queued and a strobe on the same edge -> next cycle o_tvalid=0, fifo_level=0, overflow_cnt=0.
- Drop ce_rst_n asynchronously (between clock edges) in mid-packet with o_tvalid high -> o_tvalid, fifo_level and overflow go to 0 immediately. The first packet after release has tlast on word L.
